// File: rtl/mmio_pkg.sv
// Shared bus constants and register offsets for memory-mapped peripherals.
package mmio_pkg;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic [2:0] GPIO_OUT      = 3'd0;
    localparam logic [2:0] GPIO_DIR      = 3'd1;
    localparam logic [2:0] GPIO_IN       = 3'd2;
    localparam logic [2:0] GPIO_RISE     = 3'd3;
    localparam logic [2:0] GPIO_FALL     = 3'd4;
    localparam logic [2:0] GPIO_IRQ_MASK = 3'd5;

    typedef enum logic {ARMING, RUN} gpio_arm_t;
endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for a vector of asynchronous inputs.
module gpio_sync #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [STAGES-1:0][W-1:0] r_ff;

    // shift the raw pins through STAGES flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff <= '0;
        end else begin
            r_ff[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_ff[i] <= r_ff[i-1];
        end
    end

    assign o_q = r_ff[STAGES-1];
endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: OUT/DIR registers, synchronised inputs, sticky
// rise/fall flags (W1C) and a registered read port.
// Optional level interrupt with IRQ_MASK register: define MMIO_GPIO_IRQ_EN.
module mmio_gpio
    import mmio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic [2:0]        addr,
    input  logic              re,
    input  logic [BE_W-1:0]   we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic [WIDTH-1:0]  gpio_in,
    output logic [WIDTH-1:0]  gpio_out,
    output logic [WIDTH-1:0]  gpio_oe,
    output logic              irq
);
    localparam int CNT_W = $clog2(SYNC_STAGES + 1);

    logic [WIDTH-1:0]  r_out, r_dir, r_rise, r_fall, r_prev;
    logic [DATA_W-1:0] r_rdata;
    gpio_arm_t         r_state;
    logic [CNT_W-1:0]  r_cnt;

    logic [WIDTH-1:0]  w_sync, w_wm, w_wd, w_clr_rise, w_clr_fall;
    logic [WIDTH-1:0]  w_rise, w_fall;
    logic [DATA_W-1:0] w_m32, w_rd;
    logic              w_unused;

    gpio_sync #(.W(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .i_d   (gpio_in),
        .o_q   (w_sync)
    );

    // expand byte-lane enables to a bit mask, gated by block select
    always_comb begin
        w_m32 = '0;
        for (int k = 0; k < BE_W; k++) w_m32[8*k +: 8] = {8{we[k] & sel}};
    end

    assign w_wm       = w_m32[WIDTH-1:0];
    assign w_wd       = wdata[WIDTH-1:0];
    assign w_clr_rise = (addr == GPIO_RISE) ? (w_wd & w_wm) : '0;
    assign w_clr_fall = (addr == GPIO_FALL) ? (w_wd & w_wm) : '0;
    // edges only count once the synchroniser has flushed its reset state
    assign w_rise     = (r_state == RUN) ? (w_sync & ~r_prev) : '0;
    assign w_fall     = (r_state == RUN) ? (~w_sync & r_prev) : '0;
    assign w_unused   = ^{wdata, w_m32};

`ifdef MMIO_GPIO_IRQ_EN
    logic [WIDTH-1:0] r_mask;
    logic             r_irq;

    // mask register and registered level interrupt
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (addr == GPIO_IRQ_MASK) r_mask <= (r_mask & ~w_wm) | (w_wd & w_wm);
            r_irq <= |((r_rise | r_fall) & r_mask);
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    // read mux over current (pre-write) register values
    always_comb begin
        w_rd = '0;
        case (addr)
            GPIO_OUT:      w_rd[WIDTH-1:0] = r_out;
            GPIO_DIR:      w_rd[WIDTH-1:0] = r_dir;
            GPIO_IN:       w_rd[WIDTH-1:0] = w_sync;
            GPIO_RISE:     w_rd[WIDTH-1:0] = r_rise;
            GPIO_FALL:     w_rd[WIDTH-1:0] = r_fall;
`ifdef MMIO_GPIO_IRQ_EN
            GPIO_IRQ_MASK: w_rd[WIDTH-1:0] = r_mask;
`endif
            default:       w_rd = '0;
        endcase
    end

    // arming FSM: hold off edge capture for SYNC_STAGES+1 cycles after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ARMING;
            r_cnt   <= '0;
        end else if (r_state == ARMING) begin
            if (r_cnt == CNT_W'(SYNC_STAGES)) r_state <= RUN;
            else                              r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // bus registers, edge flags (set beats clear) and registered read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out   <= '0;
            r_dir   <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_prev  <= '0;
            r_rdata <= '0;
        end else begin
            if (addr == GPIO_OUT) r_out <= (r_out & ~w_wm) | (w_wd & w_wm);
            if (addr == GPIO_DIR) r_dir <= (r_dir & ~w_wm) | (w_wd & w_wm);
            r_prev <= w_sync;
            r_rise <= (r_rise & ~w_clr_rise) | w_rise;
            r_fall <= (r_fall & ~w_clr_fall) | w_fall;
            if (sel && re) r_rdata <= w_rd;
        end
    end

    assign rdata    = r_rdata;
    assign gpio_out = r_out;
    assign gpio_oe  = r_dir;
endmodule

// File: doc/mmio_gpio.md
Name: mmio_gpio

Overview:
- Parametrised memory-mapped GPIO peripheral; the successor to the single-bit output register in the top level.
- Provides WIDTH bidirectional pins with per-pin direction, input synchronisers, sticky rise/fall edge flags and an optional level interrupt.
- Sits on the CPU word bus (addr/wdata/rdata/re/we) beside RAM and the UART.
- Read data is registered, so it has the same one-cycle read latency as RAM and the top-level rdata mux needs no extra delay stage.

Parameters:
- WIDTH, 8: number of GPIO pins, 1..32.
- SYNC_STAGES, 2: input synchroniser flops per pin, 2..4.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sel  in  1  block select, decoded by the top level from the upper address bits.
- addr  in  3  word offset within the block.
- re  in  1  read strobe.
- we  in  4  byte-lane write enables.
- wdata  in  32  write data.
- rdata  out  32  read data, valid the cycle after re.
- gpio_in  in  WIDTH  asynchronous pin inputs.
- gpio_out  out  WIDTH  pin output values.
- gpio_oe  out  WIDTH  pin output enables (1 = drive).
- irq  out  1  interrupt request, level, active-high.

Behaviour:
- Register map (word offsets):
  - 0 OUT (RW).
  - 1 DIR (RW, 1 = output).
  - 2 IN (RO, synchronised pins).
  - 3 RISE (RW1C).
  - 4 FALL (RW1C).
  - 5 IRQ_MASK (RW, only with the macro; otherwise reads 0).
  - 6, 7: read 0, writes ignored.
- Register bits at and above WIDTH read 0 and are not stored.
- Writes: take effect only when sel=1. Byte lane k updates bits [8k+7:8k] only when we[k]=1. Partial writes are legal.
- W1C: writing 1 clears that flag bit, writing 0 leaves it unchanged.
- Simultaneous edge detect and W1C on the same bit: set wins, flag stays 1.
- Reads: when sel & re, rdata is loaded at the next clk edge with the register value. Otherwise rdata holds its previous value.
- Read and write to the same register in the same cycle: rdata returns the pre-write value.
- Outputs: gpio_out = OUT and gpio_oe = DIR, both driven directly from flops with no combinational path from the bus.
- Input path: gpio_in passes through SYNC_STAGES flops to give sync. A prev register holds sync delayed by one cycle.
  - rise = sync & ~prev; fall = ~sync & prev.
  - A RISE/FALL bit sets one cycle after the edge is detected, i.e. SYNC_STAGES+1 clk edges after the pin changes (pin stable).
- Edge detection applies to all pins regardless of DIR.
- Arming state machine (suppresses spurious edges after reset):
  - States: ARMING, RUN. ARMING is entered on reset.
  - ARMING: a counter counts SYNC_STAGES+1 cycles. prev tracks sync, and RISE/FALL setting is inhibited.
  - RUN: entered when the counter reaches its terminal value. Normal edge capture; no exit except reset.
  - Bus access works in both states.
- Reset (reset=0, asynchronous): OUT, DIR, RISE, FALL, IRQ_MASK, synchroniser flops, prev, rdata all 0. Therefore gpio_out=0, gpio_oe=0, irq=0.
- Reset asserted mid-operation clears all state immediately, including a pending rdata.

Optional Feature:
- Macro: MMIO_GPIO_IRQ_EN.
- Defined:
  - IRQ_MASK register exists at offset 5, reset value 0.
  - irq = |((RISE | FALL) & IRQ_MASK), registered, so it asserts one cycle after a flag sets.
  - irq deasserts one cycle after the W1C write that clears the last enabled flag.
- Undefined: no IRQ_MASK storage, offset 5 reads 0, irq tied to 0.

Decomposition:
- Shared package mmio_pkg holds:
  - register offset constants GPIO_OUT, GPIO_DIR, GPIO_IN, GPIO_RISE, GPIO_FALL, GPIO_IRQ_MASK;
  - bus width constants DATA_W=32 and BE_W=4.
- One sub-module, gpio_sync: a per-vector SYNC_STAGES-deep synchroniser with async active-low reset, instantiated once over WIDTH bits.

Test Plan:
- Reset release with gpio_in=8'hFF held high -> RISE and FALL read 0 after 10 cycles (no spurious edges); rdata=0; gpio_oe=0.
- Write OUT=0x000000A5 with we=4'b1111, then DIR=0xFF -> gpio_out=8'hA5 and gpio_oe=8'hFF on the cycle after each write; read of offset 0 returns 0xA5 one cycle after re.
- Partial write: OUT=0x12345678 (WIDTH=32), then write 0xFFFFFFFF with we=4'b0100 -> OUT reads 0x12FF5678.
- gpio_in bit 3 goes 0->1 -> RISE reads 0x08 after SYNC_STAGES+1 cycles. Then W1C 0x08 to RISE in the same cycle as a new rise on bit 3 -> RISE still reads 0x08. A later W1C 0x08 with no edge -> RISE reads 0.
- MMIO_GPIO_IRQ_EN defined, IRQ_MASK=0x01, fall on bit 0 -> irq=1 one cycle after the FALL bit sets; W1C FALL=0x01 -> irq=0 the following cycle. Macro undefined -> irq stays 0 and offset 5 reads 0.
- Access with sel=0, or to offset 6/7 -> no register changes; a read of offset 6 with sel=1 returns 0.
